fp_div_seq: RTL

- Multi-cycle IEEE-754 single-precision divider for the FP datapath, the inverse operation of the combinational FP multiplier.
- Restoring mantissa division, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Sits beside the ALU and serves the FP divide opcode; the CPU controller stalls on it.
- Rounding (GRS = (R&S)|(G&R)) and no-special-case policy match the existing FP multiply/add units, so results are bit-consistent.

---
 rtl/fp_div_seq_pkg.sv | 16 +
 rtl/fp_div_round.sv | 52 +++++
 rtl/fp_div_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_div_seq_pkg.sv
// Shared definitions for the sequential FP32 divider: status codes, opcode and FSM states.
package fp_div_seq_pkg;

    localparam logic [1:0] R_TYPE_SUCCESS = 2'b00;
    localparam logic [1:0] MIPS_OVERFLOW  = 2'b01;

    localparam logic [5:0] OP_FP_DIV = 6'h1b;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StDiv  = 2'b01,
        StNorm = 2'b10,
        StDone = 2'b11
    } fp_div_state_e;

endpackage

// File: rtl/fp_div_round.sv
// Normalise, round and pack a 27-bit mantissa quotient into FP32, using the same
// GRS rounding and wrap-around behaviour as the FP multiplier.
module fp_div_round
    import fp_div_seq_pkg::*;
#(
    parameter int unsigned BIAS = 127
) (
    input  logic [26:0] q_i,
    input  logic        sticky_i,
    input  logic [7:0]  ea_i,
    input  logic [7:0]  eb_i,
    input  logic        sign_i,
    output logic [31:0] data_o,
    output logic [1:0]  overflow_o
);

    logic [22:0]       frac;
    logic [22:0]       frac_rnd;
    logic              g_bit;
    logic              r_bit;
    logic              s_bit;
    logic              eadj;
    logic              grs;
    logic signed [9:0] exp_s;

    always_comb begin
        if (q_i[26]) begin
            frac  = q_i[25:3];
            g_bit = q_i[3];
            r_bit = q_i[2];
            s_bit = (|q_i[1:0]) | sticky_i;
            eadj  = 1'b0;
        end else begin
            frac  = q_i[24:2];
            g_bit = q_i[2];
            r_bit = q_i[1];
            s_bit = q_i[0] | sticky_i;
            eadj  = 1'b1;
        end

        grs = (r_bit & s_bit) | (g_bit & r_bit);
        // Mantissa carry-out is dropped on purpose; the exponent is never bumped.
        frac_rnd = frac + {22'd0, grs};

        exp_s = $signed({2'b00, ea_i}) - $signed({2'b00, eb_i})
              + $signed(10'(BIAS)) - $signed({9'd0, eadj});

        overflow_o = ((exp_s < 10'sd1) || (exp_s > 10'sd254)) ? MIPS_OVERFLOW : R_TYPE_SUCCESS;
        data_o     = {sign_i, exp_s[7:0], frac_rnd};
    end

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle FP32 divider: restoring mantissa division, one quotient bit per cycle,
// valid/ready handshakes on input and output.
module fp_div_seq
    import fp_div_seq_pkg::*;
#(
    parameter int unsigned QBITS = 27,
    parameter int unsigned BIAS  = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] o_data,
    output logic [1:0]  overflow
);

    localparam logic [4:0] CntLast = 5'(QBITS - 1);

    fp_div_state_e state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [24:0] rem_q, rem_d;
    logic [23:0] div_q, div_d;
    logic [26:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] o_data_q, o_data_d;
    logic [1:0]  overflow_q, overflow_d;

    logic [24:0] diff;
    logic        qbit;
    logic [31:0] rnd_data;
    logic [1:0]  rnd_ovf;

    fp_div_round #(
        .BIAS (BIAS)
    ) u_round (
        .q_i        (q_q),
        .sticky_i   (|rem_q),
        .ea_i       (ea_q),
        .eb_i       (eb_q),
        .sign_i     (sign_q),
        .data_o     (rnd_data),
        .overflow_o (rnd_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sign_q     <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            o_data_q   <= '0;
            overflow_q <= R_TYPE_SUCCESS;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            o_data_q   <= o_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        rem_d      = rem_q;
        div_d      = div_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        o_data_d   = o_data_q;
        overflow_d = overflow_q;

        // Remainder stays below twice the divisor, so the shifted value always fits.
        if (rem_q >= {1'b0, div_q}) begin
            qbit = 1'b1;
            diff = rem_q - {1'b0, div_q};
        end else begin
            qbit = 1'b0;
            diff = rem_q;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = data1[31] ^ data2[31];
                    ea_d   = data1[30:23];
                    eb_d   = data2[30:23];
                    if (data2[30:23] == 8'd0) begin
                        o_data_d   = {data1[31] ^ data2[31], 31'd0};
                        overflow_d = MIPS_OVERFLOW;
                        state_d    = StDone;
                    end else begin
                        rem_d   = {2'b01, data1[22:0]};
                        div_d   = {1'b1, data2[22:0]};
                        q_d     = '0;
                        cnt_d   = '0;
                        state_d = StDiv;
                    end
                end
            end
            StDiv: begin
                rem_d = diff << 1;
                q_d   = {q_q[25:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CntLast) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                o_data_d   = rnd_data;
                overflow_d = rnd_ovf;
                state_d    = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign o_data    = o_data_q;
    assign overflow  = overflow_q;

endmodule
